jtvigil_obj_lbuf: RTL
=====================

// Module: jtvigil_obj_lbuf
// PURPOSE
// Double-banked object line buffer, directly downstream of the object draw engine.
// Engine writes one line of 8-bit pixels {pal[3:0],col[3:0]} into the write bank.
// Video timing reads the other bank at pixel rate; each read cell is erased behind the beam.
// Banks swap on every LHBL rising edge. Output feeds the colour mixer.
// PARAMETERS
// AW      9      address width; each bank holds 2**AW entries
// DW      8      pixel width; DW>=4
// ALPHA   4'h0   colour value (wr_data[3:0]) treated as transparent; never written
// CLR_VAL 8'h00  value loaded into erased/initialised cells
// PORTS
// clk      in   1   system clock
// rst_n    in   1   reset; one clock; reset is synchronous and active-low
// LHBL     in   1   horizontal blank, active low; rising edge = bank swap
// flip     in   1   screen flip: read address becomes ~rd_addr
// wr_addr  in   AW  engine write address; arithmetic wraps modulo 2**AW
// wr_data  in   DW  engine pixel
// we       in   1   engine write strobe, one pixel per cycle
// rd_addr  in   AW  read address (h counter)
// rd       in   1   read strobe (pixel clock enable)
// rd_data  out  DW  pixel read from read bank
// ready    out  1   high once power-on clear finished
// BEHAVIOUR
// - Reset (rst_n=0 on a clk edge): state<=INIT, init_cnt<=0, wr_bank<=0, LHBL_l<=0,
//   rd_data<=CLR_VAL, ready<=0. RAM contents are not touched by reset itself.
// - INIT: each cycle writes CLR_VAL to address init_cnt in BOTH banks, init_cnt++;
//   after address 2**AW-1 -> RUN, ready<=1 (2**AW cycles). we/rd ignored; rd_data holds CLR_VAL.
// - Reset asserted mid-INIT or mid-RUN restarts INIT from address 0.
// - RUN, swap: LHBL_l<=LHBL every cycle; on edge with LHBL && !LHBL_l, wr_bank<=~wr_bank.
//   Read bank is always ~wr_bank. Swap ignores we/rd; a write in the swap cycle uses pre-swap wr_bank.
// - Write: we=1 and wr_data[3:0]!=ALPHA -> bank[wr_bank][wr_addr]<=wr_data.
//   Transparent pixels leave the cell unchanged. Overwrite policy: see CONFIGURATION.
// - Read: rd=1 -> rd_data <= bank[~wr_bank][ra] with ra = flip ? ~rd_addr : rd_addr.
//   Registered, latency 1 clk. rd=0 -> rd_data holds.
// - Erase: the cycle after a read, CLR_VAL is written to the same ra of the bank that was read.
//   Bank id and ra are registered with the read, so a swap between the read and the erase
//   still erases the old bank.
// - Back-to-back rd: read of ra(n) and erase of ra(n-1) occur in the same cycle.
//   Same-address back-to-back reads return the pre-erase value on both reads (read priority).
// - Write and erase never target the same bank (write bank != read bank), so no collision exists.
//   Exception: erase pending across a swap lands in the new write bank. An erase and an engine
//   write to the same cell in that cycle -> engine write wins.
// - Memory: per bank, one write port shared by init/engine/erase, one read port; 2 x 2**AW x DW.
// CONFIGURATION
// JTVIGIL_OBJ_PRIO_EN defined: a write lands only if the target cell's current colour
//   nibble == ALPHA (first opaque writer wins, so earlier table entries sit on top).
//   This needs a read of the write bank before the write: 1-cycle write pipeline,
//   we may still be asserted every cycle, and a same-address write in consecutive
//   cycles sees the first write (forwarded).
// Not defined: last opaque writer wins; writes commit in the same cycle; no write-side read.
// TESTING
// 1 rst_n low 2 clk then high -> ready=0 for 512 clk then 1; every rd of either bank returns 8'h00.
// 2 we at addr 0x1FF,0x000 data 8'h35,8'h36; LHBL rise; rd 0x1FF,0x000 -> 8'h35,8'h36 one clk later;
//   re-read after the next swap pair -> 8'h00 (erased).
// 3 write 8'h50 (col 0) to addr 0x10 over existing 8'h00 -> cell stays 8'h00 after swap+read.
// 4 flip=1, write 8'h21 at 0x000, swap, rd_addr=0x1FF -> rd_data=8'h21.
// 5 addr 0x40: write 8'h12 then 8'h34; swap; read -> 8'h34 without macro, 8'h12 with JTVIGIL_OBJ_PRIO_EN.
// 6 rd at 0x20 on the same clk as the LHBL rising edge, then rst_n low mid-line ->
//   old bank cell 0x20 erased, ready drops, INIT restarts at 0.

Source files
------------

// File: rtl/jtvigil_obj_lbuf_if.sv
// Engine write, video read and status signals of the object line buffer.
interface jtvigil_obj_lbuf_if #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 8
);
  logic          LHBL;
  logic          flip;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          we;
  logic [AW-1:0] rd_addr;
  logic          rd;
  logic [DW-1:0] rd_data;
  logic          ready;

  modport master (
    output LHBL, flip, wr_addr, wr_data, we, rd_addr, rd,
    input  rd_data, ready
  );

  modport slave (
    input  LHBL, flip, wr_addr, wr_data, we, rd_addr, rd,
    output rd_data, ready
  );
endinterface

// File: rtl/jtvigil_obj_lbuf.sv
// Double-banked object line buffer with erase-behind-beam reads.
// Optional JTVIGIL_OBJ_PRIO_EN: first opaque writer wins (1-cycle write pipeline).
module jtvigil_obj_lbuf #(
  parameter int unsigned   AW      = 9,
  parameter int unsigned   DW      = 8,
  parameter logic [3:0]    ALPHA   = 4'h0,
  parameter logic [DW-1:0] CLR_VAL = DW'(8'h00)
) (
  input  logic                clk,
  input  logic                rst_n,
  jtvigil_obj_lbuf_if.slave   bus
);

  localparam int unsigned DEPTH = 2 ** AW;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] init_cnt, init_cnt_nx;
  logic          ready, ready_nx;

  logic          wr_bank;
  logic          lhbl_l;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] mem [2][DEPTH];

  logic          run;
  logic          swap;
  logic          rd_bank;
  logic          rd_go;
  logic [AW-1:0] ra;

  // Erase registered with the read, plus one deferred erase that lost its bank port
  logic          er_v, er_bank;
  logic [AW-1:0] er_addr;
  logic          hold_v, hold_bank;
  logic [AW-1:0] hold_addr;

  logic          eng_v, eng_bank;
  logic [AW-1:0] eng_addr;
  logic [DW-1:0] eng_data;

  logic [1:0]    wen;
  logic [AW-1:0] waddr [2];
  logic [DW-1:0] wdata [2];

  logic          hold_win, hold_drop, er_lost, er_drop;

  assign bus.rd_data = rd_data;
  assign bus.ready   = ready;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      ready    <= 1'b0;
    end else begin
      state    <= state_nx;
      init_cnt <= init_cnt_nx;
      ready    <= ready_nx;
    end
  end

  // Power-on clear sweeps every address once, then hands over to normal operation
  always_comb begin
    state_nx    = state;
    init_cnt_nx = init_cnt;
    ready_nx    = ready;
    case (state)
      ST_INIT: begin
        init_cnt_nx = init_cnt + AW'(1);
        if (init_cnt == AW'(DEPTH - 1)) begin
          state_nx = ST_RUN;
          ready_nx = 1'b1;
        end
      end
      ST_RUN:  state_nx = ST_RUN;
      default: state_nx = ST_INIT;
    endcase
  end

  assign run     = (state == ST_RUN);
  assign swap    = run && bus.LHBL && !lhbl_l;
  assign rd_bank = ~wr_bank;
  assign rd_go   = run && bus.rd;
  assign ra      = bus.flip ? ~bus.rd_addr : bus.rd_addr;

`ifdef JTVIGIL_OBJ_PRIO_EN
  logic          pw_v, pw_bank;
  logic [AW-1:0] pw_addr;
  logic [DW-1:0] pw_data;
  logic [DW-1:0] pw_cell;
  logic          pw_fwd;

  assign eng_v    = pw_v && (pw_cell[3:0] == ALPHA);
  assign eng_bank = pw_bank;
  assign eng_addr = pw_addr;
  assign eng_data = pw_data;
  // A cell written this cycle must be seen by the next write's priority check
  assign pw_fwd   = wen[wr_bank] && (waddr[wr_bank] == bus.wr_addr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pw_v <= 1'b0;
    end else begin
      pw_v    <= run && bus.we && (bus.wr_data[3:0] != ALPHA);
      pw_bank <= wr_bank;
      pw_addr <= bus.wr_addr;
      pw_data <= bus.wr_data;
      pw_cell <= pw_fwd ? wdata[wr_bank] : mem[wr_bank][bus.wr_addr];
    end
  end
`else
  assign eng_v    = run && bus.we && (bus.wr_data[3:0] != ALPHA);
  assign eng_bank = wr_bank;
  assign eng_addr = bus.wr_addr;
  assign eng_data = bus.wr_data;
`endif

  // Single write port per bank: clear sweep > engine > deferred erase > fresh erase
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      wen[b]   = 1'b0;
      waddr[b] = '0;
      wdata[b] = CLR_VAL;
      if (!rst_n) begin
        wen[b] = 1'b0;
      end else if (!run) begin
        wen[b]   = 1'b1;
        waddr[b] = init_cnt;
      end else if (eng_v && (eng_bank == 1'(b))) begin
        wen[b]   = 1'b1;
        waddr[b] = eng_addr;
        wdata[b] = eng_data;
      end else if (hold_v && (hold_bank == 1'(b))) begin
        wen[b]   = 1'b1;
        waddr[b] = hold_addr;
      end else if (er_v && (er_bank == 1'(b))) begin
        wen[b]   = 1'b1;
        waddr[b] = er_addr;
      end
    end
  end

  // An erase beaten by an engine write to the same cell is dropped; elsewhere it retries
  always_comb begin
    hold_win  = hold_v && !(eng_v && (eng_bank == hold_bank));
    hold_drop = hold_v && eng_v && (eng_bank == hold_bank) && (eng_addr == hold_addr);
    er_lost   = er_v && ((eng_v && (eng_bank == er_bank)) ||
                         (hold_v && (hold_bank == er_bank)));
    er_drop   = er_v && eng_v && (eng_bank == er_bank) && (eng_addr == er_addr);
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (wen[b]) mem[b][waddr[b]] <= wdata[b];
    end
  end

  // Bank swap, registered read and erase bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      lhbl_l  <= 1'b0;
      rd_data <= CLR_VAL;
      er_v    <= 1'b0;
      hold_v  <= 1'b0;
    end else begin
      lhbl_l <= bus.LHBL;
      if (swap) wr_bank <= ~wr_bank;
      er_v <= rd_go;
      if (rd_go) begin
        rd_data <= mem[rd_bank][ra];
        er_bank <= rd_bank;
        er_addr <= ra;
      end
      if (er_lost && !er_drop) begin
        hold_v    <= 1'b1;
        hold_bank <= er_bank;
        hold_addr <= er_addr;
      end else if (hold_win || hold_drop) begin
        hold_v <= 1'b0;
      end
    end
  end

endmodule
